// File: rtl/sm3_pkg.sv
// ----------------------------------------------------------------------------
// sm3_pkg
// Shared constants and types for the SM3 block packer and its block FIFO.
//   SM3_BLK_W   : message block width (512, fixed by SM3)
//   SM3_CNT_W   : width of the bit-in-block counter (0..511)
//   blk_entry_t : one FIFO entry, {data, first, last}
// ----------------------------------------------------------------------------
package sm3_pkg;

    localparam int SM3_BLK_W = 512;
    localparam int SM3_CNT_W = 9;

    typedef struct packed {
        logic [SM3_BLK_W-1:0] data;
        logic                 first;
        logic                 last;
    } blk_entry_t;

endpackage

// File: rtl/sm3_blk_fifo.sv
// ----------------------------------------------------------------------------
// sm3_blk_fifo
// Show-ahead FIFO of DEPTH message blocks (514 bits each).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   i_push      : write i_entry; ignored when full unless popping this cycle
//   i_entry     : entry to write
//   i_pop       : remove head; ignored when empty
//   o_head      : current head entry (only meaningful when !o_empty)
//   o_full      : DEPTH entries held
//   o_empty     : no entries held
// ----------------------------------------------------------------------------
module sm3_blk_fifo
    import sm3_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  blk_entry_t i_entry,
    input  logic       i_pop,
    output blk_entry_t o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);

    blk_entry_t      r_mem [DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            w_do_push;
    logic            w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the slot on the same edge, so push at full is accepted then.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_head = r_mem[r_rd_ptr[AW-1:0]];

    // Storage has no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/sm3_block_pack.sv
// ----------------------------------------------------------------------------
// sm3_block_pack
// Collects the padded SM3 bit stream into 512-bit blocks, tags the first and
// last block of each message and queues them for the compression stage.
// Optional feature macro: SM3_PACK_ERR_EN (enables the pack_err pulse).
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   data_padding     : padded message bit, MSB first
//   data_padding_en  : bit qualifier, contiguous for a whole message
//   block_data       : head block, first received bit at [511]
//   block_first      : head block is first of its message
//   block_last       : head block is last of its message
//   block_valid      : FIFO head valid
//   block_ready      : consumer takes head when valid & ready
//   pack_err         : one-cycle pulse on overflow or partial block
// ----------------------------------------------------------------------------
module sm3_block_pack
    import sm3_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int BLK_W = SM3_BLK_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_padding,
    input  logic             data_padding_en,
    output logic [BLK_W-1:0] block_data,
    output logic             block_first,
    output logic             block_last,
    output logic             block_valid,
    input  logic             block_ready,
    output logic             pack_err
);

    logic [SM3_BLK_W-2:0] r_shreg;
    logic [SM3_CNT_W-1:0] r_cnt;
    logic [SM3_BLK_W-1:0] r_pend;
    logic                 r_pend_vld;
    logic                 r_first_flag;

    logic                 w_blk_done;
    logic                 w_partial;
    logic                 w_last;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    blk_entry_t           w_entry;
    blk_entry_t           w_head;

    assign w_blk_done = data_padding_en && (r_cnt == '1);
    // en dropping mid-block; when a block just completed, r_cnt is already 0.
    assign w_partial  = !data_padding_en && (r_cnt != '0);
    // The cycle after a block completes tells whether the message continues.
    assign w_last     = !data_padding_en;
    assign w_pop      = !w_empty && block_ready;

    assign w_entry.data  = r_pend;
    assign w_entry.first = r_first_flag;
    assign w_entry.last  = w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_pend       <= '0;
            r_pend_vld   <= 1'b0;
            r_first_flag <= 1'b1;
        end else begin
            if (data_padding_en) begin
                r_shreg <= {r_shreg[SM3_BLK_W-3:0], data_padding};
                r_cnt   <= r_cnt + SM3_CNT_W'(1);
            end else if (w_partial) begin
                r_cnt <= '0;
            end

            if (w_blk_done) begin
                r_pend     <= {r_shreg, data_padding};
                r_pend_vld <= 1'b1;
            end else if (r_pend_vld) begin
                r_pend_vld <= 1'b0;
            end

            if (r_pend_vld) begin
                r_first_flag <= w_last;
            end else if (w_partial) begin
                r_first_flag <= 1'b1;
            end
        end
    end

    sm3_blk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_pend_vld),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Head is masked while empty so stale storage never reaches the outputs.
    assign block_valid = !w_empty;
    assign block_data  = w_empty ? '0   : w_head.data;
    assign block_first = w_empty ? 1'b0 : w_head.first;
    assign block_last  = w_empty ? 1'b0 : w_head.last;

`ifdef SM3_PACK_ERR_EN
    logic w_overflow;
    logic r_pack_err;

    assign w_overflow = r_pend_vld && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pack_err <= 1'b0;
        end else begin
            r_pack_err <= w_overflow || w_partial;
        end
    end

    assign pack_err = r_pack_err;
`else
    assign pack_err = 1'b0;
`endif

endmodule

// File: tb/tb_sm3_block_pack.sv
// ----------------------------------------------------------------------------
// tb_sm3_block_pack
// Self-checking bench for sm3_block_pack: a queue-based message/block model,
// a table of message shapes with expected block and error counts, and hand
// sequences for the "abc" block, latency and mid-message reset.
// ----------------------------------------------------------------------------
module tb_sm3_block_pack;

    localparam int DEPTH = 2;
`ifdef SM3_PACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         bit_i = 1'b0;
    logic         en_i = 1'b0;
    logic         rdy = 1'b0;
    logic [511:0] block_data;
    logic         block_first;
    logic         block_last;
    logic         block_valid;
    logic         pack_err;

    sm3_block_pack #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_padding    (bit_i),
        .data_padding_en (en_i),
        .block_data      (block_data),
        .block_first     (block_first),
        .block_last      (block_last),
        .block_valid     (block_valid),
        .block_ready     (rdy),
        .pack_err        (pack_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [511:0] d;
        bit           f;
        bit           l;
    } ent_t;

    ent_t         mq[$];
    logic [511:0] m_cur;
    int           m_idx;
    bit           m_pend;
    logic [511:0] m_pend_d;
    bit           m_first;
    bit           m_err;

    task automatic model_reset();
        mq.delete();
        m_cur = '0;
        m_idx = 0;
        m_pend = 0;
        m_pend_d = '0;
        m_first = 1;
        m_err = 0;
    endtask

    task automatic model_edge(input bit en, input bit b, input bit r);
        int   sz;
        bit   pop;
        bit   ovf;
        bit   part;
        ent_t e;
        sz = mq.size();
        pop = (sz > 0) && r;
        ovf = 0;
        part = 0;
        if (pop) void'(mq.pop_front());
        if (m_pend) begin
            e.d = m_pend_d;
            e.f = m_first;
            e.l = !en;
            if (sz - int'(pop) < DEPTH) mq.push_back(e);
            else ovf = 1;
            m_first = e.l;
            m_pend = 0;
        end
        if (en) begin
            m_cur[511 - m_idx] = b;
            m_idx++;
            if (m_idx == 512) begin
                m_pend = 1;
                m_pend_d = m_cur;
                m_idx = 0;
            end
        end else if (m_idx != 0) begin
            part = 1;
            m_idx = 0;
            m_first = 1;
        end
        m_err = ERR_EN && (ovf || part);
    endtask

    // ---------------- comparison helpers ----------------
    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        bit v;
        v = mq.size() > 0;
        chk1("valid", block_valid, v);
        chk1("first", block_first, v ? mq[0].f : 1'b0);
        chk1("last", block_last, v ? mq[0].l : 1'b0);
        chkd("data", block_data, v ? mq[0].d : 512'd0);
        chk1("pack_err", pack_err, m_err);
    endtask

    int pops;
    int pops_fl;
    int errs;

    // One clock: drive, edge, update model, sample #1 after the edge.
    task automatic step(input bit en, input bit b);
        en_i = en;
        bit_i = b;
        if (block_valid && rdy) begin
            pops++;
            if (block_first && block_last) pops_fl++;
        end
        @(posedge clk);
        model_edge(en, b, rdy);
        #1;
        if (pack_err) errs++;
        check_model();
    endtask

    task automatic send_random(input int nbits);
        for (int i = 0; i < nbits; i++) step(1'b1, 1'($urandom_range(0, 1)));
    endtask

    task automatic drain(input int n);
        rdy = 1'b1;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    // ---------------- table of message shapes ----------------
    typedef struct {
        string name;
        int    nbits;
        bit    ready;
        int    exp_pops;
        int    exp_errs;   // with the error pulse enabled
    } row_t;

    row_t rows[6];

    logic [511:0] abc;

    initial begin
        rows[0] = '{"one_block",    512, 1'b1, 1, 0};
        rows[1] = '{"two_blocks",  1024, 1'b1, 2, 0};
        rows[2] = '{"partial_100",  100, 1'b1, 0, 1};
        rows[3] = '{"three_rdy",   1536, 1'b1, 3, 0};
        rows[4] = '{"tail_partial", 600, 1'b1, 1, 1};
        rows[5] = '{"overflow",    1536, 1'b0, 2, 1};

        abc = {24'h616263, 8'h80, 416'd0, 64'h18};

        model_reset();
        #1;
        chk1("reset_valid", block_valid, 1'b0);
        chkd("reset_data", block_data, 512'd0);
        chk1("reset_first", block_first, 1'b0);
        chk1("reset_last", block_last, 1'b0);
        chk1("reset_err", pack_err, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // "abc": exact data, flags, and push/valid timing
        rdy = 1'b0;
        for (int i = 0; i < 511; i++) step(1'b1, abc[511 - i]);
        step(1'b1, abc[0]);
        chk1("abc_valid_after_bit511", block_valid, 1'b0);
        step(1'b0, 1'b0);
        chk1("abc_valid_next_edge", block_valid, 1'b1);
        chkd("abc_data", block_data, abc);
        chk1("abc_first", block_first, 1'b1);
        chk1("abc_last", block_last, 1'b1);
        drain(3);

        foreach (rows[k]) begin
            pops = 0;
            errs = 0;
            rdy = rows[k].ready;
            send_random(rows[k].nbits);
            step(1'b0, 1'b0);
            drain(4);
            chkn({rows[k].name, "_blocks"}, pops, rows[k].exp_pops);
            chkn({rows[k].name, "_errs"}, errs, ERR_EN ? rows[k].exp_errs : 0);
        end

        // back-to-back messages separated by a single idle cycle
        pops = 0;
        pops_fl = 0;
        rdy = 1'b1;
        send_random(512);
        step(1'b0, 1'b0);
        send_random(512);
        drain(4);
        chkn("b2b_blocks", pops, 2);
        chkn("b2b_first_last", pops_fl, 2);

        // reset asserted at bit 300 of block 2
        rdy = 1'b0;
        send_random(812);
        chk1("pre_reset_valid", block_valid, 1'b1);
        #3;
        en_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk1("rst_valid", block_valid, 1'b0);
        chkd("rst_data", block_data, 512'd0);
        chk1("rst_first", block_first, 1'b0);
        chk1("rst_last", block_last, 1'b0);
        chk1("rst_err", pack_err, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pops = 0;
        pops_fl = 0;
        errs = 0;
        step(1'b0, 1'b0);
        rdy = 1'b1;
        send_random(512);
        drain(4);
        chkn("post_reset_blocks", pops, 1);
        chkn("post_reset_first_last", pops_fl, 1);
        chkn("post_reset_errs", errs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
